// File: rtl/pbit_pkg.sv
// pbit_pkg: shared FSM states, config targets, RNG shifts and saturation helper
package pbit_pkg;

    typedef enum logic [2:0] {IDLE, ROW, MAC, UPD, SWEEP, DONE} state_e;

    localparam logic [1:0] SEL_VAL = 2'd0;
    localparam logic [1:0] SEL_COL = 2'd1;
    localparam logic [1:0] SEL_ROW = 2'd2;
    localparam logic [1:0] SEL_H   = 2'd3;

    localparam int XS_A = 13;
    localparam int XS_B = 17;
    localparam int XS_C = 5;

    function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        return (v > hi) ? hi : (v < -hi - 32'sd1) ? -hi - 32'sd1 : v;
    endfunction

endpackage

// File: rtl/pbit_rng.sv
// pbit_rng: xorshift32 generator; a zero seed is replaced by 1 so the state never locks up
module pbit_rng
    import pbit_pkg::*;
#(
    parameter int OW   = 8,
    parameter int SH_A = XS_A,
    parameter int SH_B = XS_B,
    parameter int SH_C = XS_C
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          advance,
    input  logic [31:0]   seed,
    output logic [OW-1:0] rnd
);

    logic [31:0] st_q, t1, t2, st_d;

    // one xorshift32 step from the current state
    always_comb begin
        t1   = st_q ^ (st_q << SH_A);
        t2   = t1 ^ (t1 >> SH_B);
        st_d = t2 ^ (t2 << SH_C);
    end

    // seed on load, step on advance
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) st_q <= 32'd1;
        else if (load) st_q <= (seed == '0) ? 32'd1 : seed;
        else if (advance) st_q <= st_d;

    assign rnd = st_q[OW-1:0];

endmodule

// File: rtl/pbit_sparse_gibbs_engine.sv
// pbit_sparse_gibbs_engine: sequential Gibbs sampler over a CSR-coupled p-bit network
// with one serial MAC; define PBIT_ANNEAL_EN to add per-sweep beta annealing.
module pbit_sparse_gibbs_engine
    import pbit_pkg::*;
#(
    parameter int NUM_PBITS = 96,
    parameter int NNZ_MAX   = 512,
    parameter int W_WIDTH   = 8,
    parameter int FRAC_BITS = 3,
    parameter int NUM_OUT   = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  logic [$clog2(NNZ_MAX+1)-1:0] cfg_addr,
    input  logic [15:0]                  cfg_data,
    input  logic [31:0]                  seed,
    input  logic [W_WIDTH-1:0]           beta_init,
`ifdef PBIT_ANNEAL_EN
    input  logic [W_WIDTH-1:0]           beta_step,
    input  logic [W_WIDTH-1:0]           beta_max,
`endif
    input  logic                         start,
    input  logic [15:0]                  num_sweeps,
    input  logic                         clamp_en,
    input  logic [NUM_PBITS-1:0]         clamp_mask,
    input  logic [NUM_PBITS-1:0]         clamp_val,
    output logic                         busy,
    output logic                         done,
    output logic                         out_valid,
    output logic [15:0]                  sweep_cnt,
    output logic [NUM_PBITS-1:0]         m,
    output logic [NUM_OUT-1:0]           out
);

    localparam int AW = $clog2(NNZ_MAX + 1);
    localparam int KW = $clog2(NNZ_MAX);
    localparam int IW = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;
    localparam int RW = $clog2(NUM_PBITS + 1);
    localparam int CW = W_WIDTH + $clog2(NNZ_MAX) + 1;

    logic signed [W_WIDTH-1:0] val_mem [NNZ_MAX];
    logic [15:0]               col_mem [NNZ_MAX];
    logic [AW-1:0]             rp_mem  [NUM_PBITS+1];
    logic signed [W_WIDTH-1:0] h_mem   [NUM_PBITS];

    state_e                state_q;
    logic [IW-1:0]         i_q;
    logic [AW-1:0]         k_q, e_q;
    logic signed [CW-1:0]  acc_q;
    logic                  clamp_q, cval_q, busy_q, done_q, valid_q;
    logic [NUM_PBITS-1:0]  m_q;
    logic [15:0]           sweeps_q, target_q;
    logic [W_WIDTH-1:0]    beta_q, beta_d;
`ifdef PBIT_ANNEAL_EN
    logic [W_WIDTH-1:0]    step_q, max_q;
    logic [W_WIDTH:0]      beta_sum;
`endif

    logic [AW-1:0]         row_s, row_e;
    logic                  row_cl, bit_d;
    logic [15:0]           col;
    logic signed [CW-1:0]  term;
    logic signed [31:0]    field, prod, x;
    logic [W_WIDTH-1:0]    rnd;

    pbit_rng #(.OW(W_WIDTH)) u_rng (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_q == IDLE && start),
        .advance (state_q == UPD),
        .seed    (seed),
        .rnd     (rnd)
    );

    // row bounds, MAC term, field/threshold decision and next beta
    always_comb begin
        row_s  = rp_mem[RW'(i_q)];
        row_e  = rp_mem[RW'(i_q) + RW'(1)];
        row_cl = clamp_en & clamp_mask[i_q];
        col    = (32'(k_q) < NNZ_MAX) ? col_mem[k_q[KW-1:0]] : '1;
        term   = (32'(col) < NUM_PBITS && |(m_q & (NUM_PBITS'(1) << col))) ? CW'(val_mem[k_q[KW-1:0]]) : '0;
        field  = sat_w(sat_w(32'(acc_q), W_WIDTH) + 32'(h_mem[i_q]), W_WIDTH);
        prod   = field * 32'($signed(beta_q));
        x      = sat_w(prod >>> FRAC_BITS, W_WIDTH);
        bit_d  = clamp_q ? cval_q : (x > 32'($signed(rnd)));
`ifdef PBIT_ANNEAL_EN
        beta_sum = {1'b0, beta_q} + {1'b0, step_q};
        beta_d   = beta_sum[W_WIDTH] ? '1 : beta_sum[W_WIDTH-1:0];
        beta_d   = (beta_d > max_q) ? max_q : beta_d;
`else
        beta_d = beta_q;
`endif
    end

    // configuration memories accept writes only while idle
    always_ff @(posedge clk)
        if (cfg_we && !busy_q) begin
            if (cfg_sel == SEL_VAL && 32'(cfg_addr) < NNZ_MAX) val_mem[cfg_addr[KW-1:0]] <= cfg_data[W_WIDTH-1:0];
            if (cfg_sel == SEL_COL && 32'(cfg_addr) < NNZ_MAX) col_mem[cfg_addr[KW-1:0]] <= cfg_data;
            if (cfg_sel == SEL_ROW && 32'(cfg_addr) <= NUM_PBITS) rp_mem[cfg_addr[RW-1:0]] <= cfg_data[AW-1:0];
            if (cfg_sel == SEL_H && 32'(cfg_addr) < NUM_PBITS) h_mem[cfg_addr[IW-1:0]] <= cfg_data[W_WIDTH-1:0];
        end

    // sweep controller: ROW fetch, serial MAC, per-p-bit update, sweep bookkeeping
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            k_q      <= '0;
            e_q      <= '0;
            acc_q    <= '0;
            clamp_q  <= 1'b0;
            cval_q   <= 1'b0;
            m_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            sweeps_q <= '0;
            target_q <= '0;
            beta_q   <= '0;
`ifdef PBIT_ANNEAL_EN
            step_q   <= '0;
            max_q    <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    beta_q   <= beta_init;
                    target_q <= num_sweeps;
                    sweeps_q <= '0;
                    i_q      <= '0;
`ifdef PBIT_ANNEAL_EN
                    step_q   <= beta_step;
                    max_q    <= beta_max;
`endif
                    busy_q   <= num_sweeps != '0;
                    done_q   <= num_sweeps == '0;
                    state_q  <= (num_sweeps == '0) ? DONE : ROW;
                end
                ROW: begin
                    k_q     <= row_s;
                    e_q     <= row_e;
                    acc_q   <= '0;
                    clamp_q <= row_cl;
                    cval_q  <= clamp_val[i_q];
                    state_q <= (row_cl || row_e <= row_s) ? UPD : MAC;
                end
                MAC: begin
                    acc_q <= acc_q + term;
                    k_q   <= k_q + AW'(1);
                    if (k_q == e_q - AW'(1)) state_q <= UPD;
                end
                UPD: begin
                    m_q[i_q] <= bit_d;
                    if (32'(i_q) < NUM_PBITS - 1) begin
                        i_q     <= i_q + IW'(1);
                        state_q <= ROW;
                    end else begin
                        sweeps_q <= sweeps_q + 16'd1;
                        valid_q  <= 1'b1;
                        state_q  <= SWEEP;
                    end
                end
                SWEEP: begin
                    beta_q <= beta_d;
                    i_q    <= '0;
                    if (sweeps_q == target_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else state_q <= ROW;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign sweep_cnt = sweeps_q;
    assign m         = m_q;
    assign out       = m_q[NUM_PBITS-NUM_OUT +: NUM_OUT];

endmodule
